// File: rtl/master_port.sv
// master_port: parallel request to serial bus master (address/data shift-out, read shift-in).
// Optional response watchdog is enabled by defining MASTER_PORT_TIMEOUT_EN.
module master_port #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wren,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              validIn,
  output logic              wren,
  output logic              Address,
  output logic              DataIn,
  input  logic              ready,
  input  logic              validOut,
  input  logic              DataOut
);

  localparam int CW = $clog2(ADDR_W + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    WAIT_WR = 3'd2,
    WAIT_RD = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] addr_sr_r, addr_sr_s;
  logic [DATA_W-1:0] data_sr_r, data_sr_s;
  logic [DATA_W-1:0] rd_sr_r, rd_sr_s;
  logic [DATA_W-1:0] rdata_r, rdata_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic              dropped_r, dropped_s;
  logic              rd_bit_s;
  logic              req_ready_r, rsp_valid_r, err_r, validin_r, wren_r, address_r, datain_r;
  logic              rsp_valid_s, err_s, validin_s, wren_s, address_s, datain_s;

`ifdef MASTER_PORT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_r, tcnt_s;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT == 0);
`endif

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rdata_r;
  assign rsp_err   = err_r;
  assign validIn   = validin_r;
  assign wren      = wren_r;
  assign Address   = address_r;
  assign DataIn    = datain_r;

  // Next-state and next-output computation for the transaction sequencer
  always_comb begin
    state_s     = state_r;
    addr_sr_s   = addr_sr_r;
    data_sr_s   = data_sr_r;
    rd_sr_s     = rd_sr_r;
    rdata_s     = rdata_r;
    cnt_s       = cnt_r;
    dropped_s   = dropped_r;
    rsp_valid_s = 1'b0;
    err_s       = err_r;
    validin_s   = validin_r;
    wren_s      = wren_r;
    address_s   = 1'b0;
    datain_s    = 1'b0;
    // Once validOut falls during a read burst, every remaining bit reads as 0
    rd_bit_s    = validOut & DataOut & ~dropped_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_s   = ADDR;
          addr_sr_s = req_addr;
          data_sr_s = req_wren ? req_wdata : {DATA_W{1'b0}};
          validin_s = 1'b1;
          wren_s    = req_wren;
          cnt_s     = {CW{1'b0}};
        end else begin
          validin_s = 1'b0;
          wren_s    = 1'b0;
        end
      end
      ADDR: begin
        if (cnt_r == CW'(ADDR_W)) begin
          validin_s = 1'b0;
          state_s   = wren_r ? WAIT_WR : WAIT_RD;
        end else begin
          address_s = addr_sr_r[ADDR_W-1];
          addr_sr_s = addr_sr_r << 1;
          // Write data rides alongside the last DATA_W address bits
          if (cnt_r >= CW'(ADDR_W - DATA_W)) begin
            datain_s  = data_sr_r[DATA_W-1];
            data_sr_s = data_sr_r << 1;
          end else begin
            datain_s  = 1'b0;
          end
          cnt_s = cnt_r + CW'(1);
        end
      end
      WAIT_WR: begin
        if (ready) begin
          state_s     = DONE;
          wren_s      = 1'b0;
          rsp_valid_s = 1'b1;
          rdata_s     = {DATA_W{1'b0}};
          err_s       = 1'b0;
        end else begin
          state_s = WAIT_WR;
        end
      end
      WAIT_RD: begin
        if (validOut) begin
          rd_sr_s   = DATA_W'(DataOut);
          cnt_s     = CW'(1);
          dropped_s = 1'b0;
          if (DATA_W == 1) begin
            state_s     = DONE;
            rdata_s     = DATA_W'(DataOut);
            rsp_valid_s = 1'b1;
            err_s       = 1'b0;
          end else begin
            state_s = RD_DATA;
          end
        end else begin
          state_s = WAIT_RD;
        end
      end
      RD_DATA: begin
        dropped_s = dropped_r | ~validOut;
        rd_sr_s   = (rd_sr_r << 1) | DATA_W'(rd_bit_s);
        cnt_s     = cnt_r + CW'(1);
        if (cnt_r == CW'(DATA_W - 1)) begin
          state_s     = DONE;
          rdata_s     = (rd_sr_r << 1) | DATA_W'(rd_bit_s);
          rsp_valid_s = 1'b1;
          err_s       = 1'b0;
        end else begin
          state_s = RD_DATA;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
`ifdef MASTER_PORT_TIMEOUT_EN
    tcnt_s = {TW{1'b0}};
    if ((state_r == WAIT_WR || state_r == WAIT_RD || state_r == RD_DATA) && state_s == state_r) begin
      if (tcnt_r == TW'(TIMEOUT - 1)) begin
        state_s     = DONE;
        rsp_valid_s = 1'b1;
        err_s       = 1'b1;
        rdata_s     = {DATA_W{1'b0}};
        wren_s      = 1'b0;
      end else begin
        tcnt_s = tcnt_r + TW'(1);
      end
    end else begin
      tcnt_s = {TW{1'b0}};
    end
`endif
  end

  // State and registered output update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      addr_sr_r   <= {ADDR_W{1'b0}};
      data_sr_r   <= {DATA_W{1'b0}};
      rd_sr_r     <= {DATA_W{1'b0}};
      rdata_r     <= {DATA_W{1'b0}};
      cnt_r       <= {CW{1'b0}};
      dropped_r   <= 1'b0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      err_r       <= 1'b0;
      validin_r   <= 1'b0;
      wren_r      <= 1'b0;
      address_r   <= 1'b0;
      datain_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      addr_sr_r   <= addr_sr_s;
      data_sr_r   <= data_sr_s;
      rd_sr_r     <= rd_sr_s;
      rdata_r     <= rdata_s;
      cnt_r       <= cnt_s;
      dropped_r   <= dropped_s;
      req_ready_r <= (state_s == IDLE);
      rsp_valid_r <= rsp_valid_s;
      err_r       <= err_s;
      validin_r   <= validin_s;
      wren_r      <= wren_s;
      address_r   <= address_s;
      datain_r    <= datain_s;
    end
  end

`ifdef MASTER_PORT_TIMEOUT_EN
  // Watchdog counter for the slave-wait states
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_r <= {TW{1'b0}};
    end else begin
      tcnt_r <= tcnt_s;
    end
  end
`endif

endmodule

// File: tb/tb_master_port.sv
// Randomized scoreboard bench for master_port: stimulus pushes expected serial frames and
// responses; independent monitors pop and compare when the DUT presents them.
module tb_master_port;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_wren;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready, rsp_valid, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              validIn, wren, Address, DataIn;
  logic              ready, validOut, DataOut;

  master_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wren(req_wren), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .validIn(validIn), .wren(wren), .Address(Address), .DataIn(DataIn),
    .ready(ready), .validOut(validOut), .DataOut(DataOut)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata; logic wr; } ser_t;
  typedef struct { logic [DATA_W-1:0] rdata; logic err; int cyc; } rsp_t;
  ser_t ser_q[$];
  rsp_t rsp_q[$];
  int last_rsp_cyc = -100;
  int gap_last = 0;

  // Serial-side monitor: rebuilds the address/data frame shown on the bus
  ser_t cur;
  int k_s = 0;
  logic cap = 1'b0;
  logic bad = 1'b0;
  logic [ADDR_W-1:0] ag, dg;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      cap = 1'b0;
    end else if (validIn === 1'b1) begin
      if (!cap) begin
        cap = 1'b1; k_s = 0; ag = '0; dg = '0; bad = 1'b0;
        if (ser_q.size() == 0) begin
          chk("ser_unexpected", 32'd1, 32'd0);
          cur = '{addr: '0, wdata: '0, wr: 1'b0};
        end else begin
          cur = ser_q.pop_front();
        end
        chk("ser_cycle0_lines", 32'({Address, DataIn}), 32'd0);
      end else begin
        k_s = k_s + 1;
        if (k_s <= ADDR_W) begin
          ag[ADDR_W-k_s] = Address;
          dg[ADDR_W-k_s] = DataIn;
        end
      end
      if (wren !== cur.wr || req_ready !== 1'b0) bad = 1'b1;
    end else if (cap) begin
      cap = 1'b0;
      chk("ser_addr", 32'(ag), 32'(cur.addr));
      chk("ser_datain", 32'(dg), cur.wr ? 32'(cur.wdata) : 32'd0);
      chk("ser_len", 32'(k_s), 32'(ADDR_W));
      chk("ser_wren_busy", 32'(bad), 32'd0);
      chk("ser_tail_lines", 32'({Address, DataIn}), 32'd0);
    end
  end

  // Response monitor: pops the scoreboard on every rsp_valid pulse
  logic prev_rv = 1'b0;
  logic [DATA_W-1:0] held = '0;
  rsp_t rr;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      prev_rv = 1'b0;
      held = '0;
    end else begin
      if (rsp_valid === 1'b1) begin
        chk("rsp_single_pulse", 32'(prev_rv), 32'd0);
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          rr = rsp_q.pop_front();
          chk("rsp_rdata", 32'(rsp_rdata), 32'(rr.rdata));
          chk("rsp_err", 32'(rsp_err), 32'(rr.err));
          chk("rsp_cycle", 32'(cyc), 32'(rr.cyc));
          held = rr.rdata;
        end
        last_rsp_cyc = cyc;
      end else begin
        chk("rsp_rdata_hold", 32'(rsp_rdata), 32'(held));
      end
      prev_rv = rsp_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (req_ready !== 1'b1 && t < 400) begin tick(); t++; end
    chk("ready_wait_bound", 32'(t < 400), 32'd1);
  endtask

  // One transaction; dly<0 means the slave never answers; k = read bits before validOut drops
  task automatic do_txn(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                        input int dly, input logic [DATA_W-1:0] sd, input int k,
                        input logic keep, input logic [ADDR_W-1:0] a2);
    int t, c0;
    rsp_t r;
    ser_t s;
    wait_ready();
    req_valid = 1'b1; req_wren = wr; req_addr = a; req_wdata = wd;
    s.addr = a; s.wdata = wd; s.wr = wr;
    ser_q.push_back(s);
    ready = 1'($urandom); validOut = 1'($urandom); DataOut = 1'($urandom);
    tick();
    c0 = cyc;
    gap_last = c0 - last_rsp_cyc;
    if (keep) begin
      req_addr = a2; req_wren = 1'b0;
    end else begin
      req_valid = 1'b0;
    end
    if (dly >= 0) begin
      r.err = 1'b0;
      r.rdata = wr ? '0 : (sd & ({DATA_W{1'b1}} << (DATA_W - k)));
      r.cyc = wr ? c0 + ADDR_W + 2 + dly : c0 + ADDR_W + 1 + dly + DATA_W;
      rsp_q.push_back(r);
    end else begin
`ifdef MASTER_PORT_TIMEOUT_EN
      r.err = 1'b1; r.rdata = '0; r.cyc = c0 + ADDR_W + 1 + TIMEOUT;
      rsp_q.push_back(r);
`endif
    end
    t = 0;
    while (validIn === 1'b1 && t < 100) begin tick(); t++; end
    chk("validin_drop_bound", 32'(t < 100), 32'd1);
    ready = 1'b0; validOut = 1'b0; DataOut = 1'b0;
    if (dly >= 0) begin
      repeat (dly) tick();
      if (wr) begin
        ready = 1'b1; tick(); ready = 1'b0;
      end else begin
        for (int i = 0; i < DATA_W; i++) begin
          validOut = (i < k);
          DataOut = (i < k) ? sd[DATA_W-1-i] : 1'($urandom);
          tick();
        end
      end
      validOut = 1'b0; DataOut = 1'b0;
    end
  endtask

  initial begin
    int t;
    rst = 1'b1; req_valid = 1'b0; req_wren = 1'b0; req_addr = '0; req_wdata = '0;
    ready = 1'b0; validOut = 1'b0; DataOut = 1'b0;
    repeat (3) tick();
    chk("reset_state", 32'({validIn, wren, Address, DataIn, rsp_valid, rsp_err, req_ready}), 32'd1);
    chk("reset_rdata", 32'(rsp_rdata), 32'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    do_txn(1'b1, 12'h24D, 8'hA5, 3, 8'h00, DATA_W, 1'b0, 12'h000);
    do_txn(1'b0, 12'h123, 8'h00, 2, 8'h3C, DATA_W, 1'b0, 12'h000);
    do_txn(1'b0, 12'hFFF, 8'h00, 0, 8'hFF, 3, 1'b0, 12'h000);
    do_txn(1'b1, 12'h000, 8'hFF, 0, 8'h00, DATA_W, 1'b0, 12'h000);
    do_txn(1'b0, 12'h0F0, 8'h00, 1, 8'h96, DATA_W, 1'b1, 12'hABC);
    do_txn(1'b0, 12'hABC, 8'h00, 0, 8'h69, DATA_W, 1'b0, 12'h000);
    chk("held_req_gap", 32'(gap_last), 32'd2);

    for (int i = 0; i < 25; i++) begin
      logic w;
      int kk;
      w = 1'($urandom);
      kk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DATA_W)) : DATA_W;
      do_txn(w, ADDR_W'($urandom), DATA_W'($urandom), int'($urandom_range(0, 5)),
             DATA_W'($urandom), kk, 1'b0, 12'h000);
    end

    // Reset asserted on cycle 6 of a write
    wait_ready();
    req_valid = 1'b1; req_wren = 1'b1; req_addr = 12'h5A5; req_wdata = 8'hC3;
    ser_q.push_back('{addr: 12'h5A5, wdata: 8'hC3, wr: 1'b1});
    tick();
    req_valid = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    ser_q.delete();
    rsp_q.delete();
    tick();
    chk("rst_serial_zero", 32'({validIn, wren, Address, DataIn}), 32'd0);
    chk("rst_no_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("ready_after_release", 32'(req_ready), 32'd1);
    repeat (10) tick();

    // Slave never answers a write
    do_txn(1'b1, 12'h3C3, 8'h5A, -1, 8'h00, DATA_W, 1'b0, 12'h000);
`ifdef MASTER_PORT_TIMEOUT_EN
    t = 0;
    while (rsp_q.size() != 0 && t < TIMEOUT + 50) begin tick(); t++; end
    chk("timeout_rsp_seen", 32'(rsp_q.size()), 32'd0);
`else
    repeat (TIMEOUT + 40) tick();
    chk("stuck_wait_wr", 32'({req_ready, wren, rsp_err}), 32'b010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`endif

    do_txn(1'b0, 12'h7E7, 8'h00, 1, 8'hE1, DATA_W, 1'b0, 12'h000);
    t = 0;
    while (rsp_q.size() != 0 && t < 100) begin tick(); t++; end
    chk("scoreboard_drained", 32'(rsp_q.size() + ser_q.size()), 32'd0);
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
